// File: rtl/ym3438_dac_pkg.sv
// Shared constants, frame-accumulator states and the PCM DAC sample mapping for the YM3438
// DAC output stage.
package ym3438_dac_pkg;

  localparam int unsigned ACC_W  = 9;
  localparam int unsigned MIX_W  = 12;
  localparam int unsigned NUM_CH = 6;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic {
    StIdle,
    StRun
  } acc_st_e;

  // Offset-binary PCM byte to signed 9-bit sample, test bit as LSB.
  function automatic logic [ACC_W-1:0] dac_pcm_to_smp(input logic [7:0] dac_data,
                                                      input logic       dac_test);
    return {~dac_data[7], dac_data[6:0], dac_test};
  endfunction

endpackage

// File: rtl/ym3438_dac_frame_acc.sv
// One side (L or R) of the per-frame channel mixer: sums the six channel samples of a frame
// and latches the total at the next frame boundary if the load count was exactly right.
module ym3438_dac_frame_acc
  import ym3438_dac_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             c1_i,
  input  logic             sel0_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] contrib_i,
  output logic [MIX_W-1:0] mix_o,
  output logic             mix_valid_o,
  output logic             seq_err_o
);

  acc_st_e          st_q, st_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [MIX_W-1:0] acc_q, acc_d;
  logic [MIX_W-1:0] mix_q, mix_d;
  logic             mix_valid_q, mix_valid_d;
  logic             seq_err_q, seq_err_d;
  logic [MIX_W-1:0] contrib_ext;

  assign contrib_ext = {{(MIX_W - ACC_W){contrib_i[ACC_W-1]}}, contrib_i};

  always_comb begin
    st_d        = st_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    seq_err_d   = seq_err_q;
    if (c1_i) begin
      if (sel0_i) begin
        if (st_q == StRun) begin
          if (idx_q == IDX_W'(NUM_CH)) begin
            mix_d       = acc_q;
            mix_valid_d = 1'b1;
          end else begin
            seq_err_d = 1'b1;
          end
        end else begin
          st_d = StRun;
        end
        acc_d = load_i ? contrib_ext : '0;
        idx_d = load_i ? IDX_W'(1) : '0;
      end else if (load_i) begin
        if (idx_q < IDX_W'(NUM_CH)) begin
          acc_d = acc_q + contrib_ext;
          idx_d = idx_q + IDX_W'(1);
        end else begin
          // Surplus load: pin idx past NUM_CH so the boundary check also fails.
          idx_d     = IDX_W'(NUM_CH + 1);
          seq_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q        <= StIdle;
      idx_q       <= '0;
      acc_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign mix_o       = mix_q;
  assign mix_valid_o = mix_valid_q;
  assign seq_err_o   = seq_err_q;

endmodule

// File: rtl/ym3438_dac_out.sv
// YM3438 DAC output stage: captures channel samples on load strobes, applies the channel-6
// PCM substitution and pan, drives per-slot samples and per-frame L/R mix totals.
module ym3438_dac_out
  import ym3438_dac_pkg::*;
(
  input  logic             MCLK,
  input  logic             reset,
  input  logic             c1,
  input  logic             fsm_sel0,
  input  logic             fsm_dac_load,
  input  logic             fsm_dac_out_sel,
  input  logic             fsm_dac_ch6,
  input  logic [ACC_W-1:0] ch_acc,
  input  logic             pan_l,
  input  logic             pan_r,
  input  logic             dac_en,
  input  logic [7:0]       dac_data,
  input  logic             dac_test,
  output logic [ACC_W-1:0] dac_slot_l,
  output logic [ACC_W-1:0] dac_slot_r,
  output logic             dac_slot_valid,
  output logic [MIX_W-1:0] mix_l,
  output logic [MIX_W-1:0] mix_r,
  output logic             mix_valid,
  output logic             seq_err
);

  logic [ACC_W-1:0] smp, contrib_l, contrib_r;
  logic [ACC_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [ACC_W-1:0] slot_l_q, slot_l_d, slot_r_q, slot_r_d;
  logic             slot_valid_q, slot_valid_d;
  logic             mix_valid_l, mix_valid_r, seq_err_l, seq_err_r;

  assign smp       = (fsm_dac_ch6 && dac_en) ? dac_pcm_to_smp(dac_data, dac_test) : ch_acc;
  assign contrib_l = pan_l ? smp : '0;
  assign contrib_r = pan_r ? smp : '0;

  // Slot output reads the pre-load hold value, so a same-cycle load shows up one slot later.
  always_comb begin
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    slot_l_d     = slot_l_q;
    slot_r_d     = slot_r_q;
    slot_valid_d = slot_valid_q;
    if (c1) begin
      if (fsm_dac_load) begin
        hold_l_d = contrib_l;
        hold_r_d = contrib_r;
      end
      slot_l_d     = fsm_dac_out_sel ? hold_l_q : '0;
      slot_r_d     = fsm_dac_out_sel ? hold_r_q : '0;
      slot_valid_d = fsm_dac_out_sel;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      slot_l_q     <= '0;
      slot_r_q     <= '0;
      slot_valid_q <= 1'b0;
    end else begin
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      slot_l_q     <= slot_l_d;
      slot_r_q     <= slot_r_d;
      slot_valid_q <= slot_valid_d;
    end
  end

  assign dac_slot_l     = slot_l_q;
  assign dac_slot_r     = slot_r_q;
  assign dac_slot_valid = slot_valid_q;

  ym3438_dac_frame_acc u_acc_l (
    .clk_i       (MCLK),
    .reset_i     (reset),
    .c1_i        (c1),
    .sel0_i      (fsm_sel0),
    .load_i      (fsm_dac_load),
    .contrib_i   (contrib_l),
    .mix_o       (mix_l),
    .mix_valid_o (mix_valid_l),
    .seq_err_o   (seq_err_l)
  );

  ym3438_dac_frame_acc u_acc_r (
    .clk_i       (MCLK),
    .reset_i     (reset),
    .c1_i        (c1),
    .sel0_i      (fsm_sel0),
    .load_i      (fsm_dac_load),
    .contrib_i   (contrib_r),
    .mix_o       (mix_r),
    .mix_valid_o (mix_valid_r),
    .seq_err_o   (seq_err_r)
  );

  // Both sides run identical sequencing, so their flags always agree.
  assign mix_valid = mix_valid_l & mix_valid_r;
  assign seq_err   = seq_err_l | seq_err_r;

endmodule

// File: tb/tb_ym3438_dac_out.sv
// Directed bench for ym3438_dac_out: table of whole frames plus hand-written corner sequences.
module tb_ym3438_dac_out;
  import ym3438_dac_pkg::*;

  logic             MCLK = 1'b0;
  logic             reset, c1, fsm_sel0, fsm_dac_load, fsm_dac_out_sel, fsm_dac_ch6;
  logic [ACC_W-1:0] ch_acc;
  logic             pan_l, pan_r, dac_en, dac_test;
  logic [7:0]       dac_data;
  logic [ACC_W-1:0] dac_slot_l, dac_slot_r;
  logic             dac_slot_valid, mix_valid, seq_err;
  logic [MIX_W-1:0] mix_l, mix_r;

  ym3438_dac_out dut (
    .MCLK            (MCLK),
    .reset           (reset),
    .c1              (c1),
    .fsm_sel0        (fsm_sel0),
    .fsm_dac_load    (fsm_dac_load),
    .fsm_dac_out_sel (fsm_dac_out_sel),
    .fsm_dac_ch6     (fsm_dac_ch6),
    .ch_acc          (ch_acc),
    .pan_l           (pan_l),
    .pan_r           (pan_r),
    .dac_en          (dac_en),
    .dac_data        (dac_data),
    .dac_test        (dac_test),
    .dac_slot_l      (dac_slot_l),
    .dac_slot_r      (dac_slot_r),
    .dac_slot_valid  (dac_slot_valid),
    .mix_l           (mix_l),
    .mix_r           (mix_r),
    .mix_valid       (mix_valid),
    .seq_err         (seq_err)
  );

  always #5 MCLK = ~MCLK;

  // One frame of stimulus plus what must be seen right after that frame's sel0 slot.
  typedef struct {
    int         ch;
    int         ch6v;
    logic       pl;
    logic       pr;
    logic       den;
    logic [7:0] dd;
    logic       dt;
    int         nl;
    logic       ev;
    int         eml;
    int         emr;
    logic       eerr;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_hold_l = 0;
  int   exp_hold_r = 0;
  vec_t tv[8];
  vec_t nv;

  function automatic vec_t mk(input int ch, input int ch6v, input logic pl, input logic pr,
                              input logic den, input logic [7:0] dd, input logic dt,
                              input int nl, input logic ev, input int eml, input int emr,
                              input logic eerr);
    vec_t v;
    v.ch = ch; v.ch6v = ch6v; v.pl = pl; v.pr = pr; v.den = den; v.dd = dd; v.dt = dt;
    v.nl = nl; v.ev = ev; v.eml = eml; v.emr = emr; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge MCLK); #1;
    reset = 1'b0;
    exp_hold_l = 0;
    exp_hold_r = 0;
  endtask

  // Drive one c1 slot of a frame, advance one MCLK, check the per-slot outputs.
  task automatic slot(input int s, input vec_t v);
    logic ld, c6;
    int   smp, esl, esr;
    ld  = ((s % 4 == 0) && (s / 4 < v.nl)) || (v.nl == 7 && s == 22);
    c6  = (s == 4);
    c1 = 1'b1;
    fsm_sel0        = (s == 0);
    fsm_dac_load    = ld;
    fsm_dac_out_sel = (s >= 12);
    fsm_dac_ch6     = c6;
    ch_acc   = 9'(c6 ? v.ch6v : v.ch);
    pan_l    = v.pl;
    pan_r    = v.pr;
    dac_en   = v.den;
    dac_data = v.dd;
    dac_test = v.dt;
    smp = (c6 && v.den) ? (int'(v.dd) - 128) * 2 + int'(v.dt) : (c6 ? v.ch6v : v.ch);
    esl = (s >= 12) ? exp_hold_l : 0;
    esr = (s >= 12) ? exp_hold_r : 0;
    if (ld) begin
      exp_hold_l = v.pl ? smp : 0;
      exp_hold_r = v.pr ? smp : 0;
    end
    @(posedge MCLK); #1;
    chk($sformatf("slot%0d_l", s), int'($signed(dac_slot_l)), esl);
    chk($sformatf("slot%0d_r", s), int'($signed(dac_slot_r)), esr);
    chk($sformatf("slot%0d_valid", s), int'(dac_slot_valid), int'(s >= 12));
  endtask

  task automatic chk_frame(input string name, input logic ev, input int eml, input int emr,
                           input logic eerr);
    chk({name, "_mix_valid"}, int'(mix_valid), int'(ev));
    chk({name, "_mix_l"}, int'($signed(mix_l)), eml);
    chk({name, "_mix_r"}, int'($signed(mix_r)), emr);
    chk({name, "_seq_err"}, int'(seq_err), int'(eerr));
  endtask

  initial begin
    reset = 1'b0; c1 = 1'b0; fsm_sel0 = 1'b0; fsm_dac_load = 1'b0; fsm_dac_out_sel = 1'b0;
    fsm_dac_ch6 = 1'b0; ch_acc = '0; pan_l = 1'b0; pan_r = 1'b0; dac_en = 1'b0;
    dac_data = 8'h00; dac_test = 1'b0;

    //           ch    ch6v  pl pr den dd     dt nl ev  eml    emr  eerr
    tv[0] = mk(  10,   10,   1, 1, 0,  8'h00, 0, 6, 0,  0,     0,   0);
    tv[1] = mk(  10,   10,   1, 1, 0,  8'h00, 0, 6, 1,  60,    60,  0);
    tv[2] = mk(-256, -256,   1, 0, 0,  8'h00, 0, 6, 1,  60,    60,  0);
    tv[3] = mk(   0,    0,   1, 1, 1,  8'hFF, 1, 6, 1,  -1536, 0,   0);
    tv[4] = mk(   0,    5,   1, 1, 0,  8'hFF, 1, 6, 1,  255,   255, 0);
    tv[5] = mk(  10,   10,   1, 1, 0,  8'h00, 0, 5, 1,  5,     5,   0);
    tv[6] = mk(   1,    1,   1, 1, 0,  8'h00, 0, 6, 0,  5,     5,   1);
    tv[7] = mk(   0,    0,   1, 1, 0,  8'h00, 0, 6, 1,  6,     6,   1);

    do_reset();
    chk_frame("reset", 1'b0, 0, 0, 1'b0);
    chk("reset_slot_l", int'(dac_slot_l), 0);
    chk("reset_slot_valid", int'(dac_slot_valid), 0);

    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < 24; s++) begin
        slot(s, tv[i]);
        if (s == 0) chk_frame($sformatf("frame%0d", i), tv[i].ev, tv[i].eml, tv[i].emr,
                              tv[i].eerr);
        if (s == 1) chk($sformatf("frame%0d_pulse", i), int'(mix_valid), 0);
      end
    end

    // Seven loads: seq_err rises on the seventh, not before.
    do_reset();
    nv = mk(7, 7, 1, 1, 0, 8'h00, 0, 7, 0, 0, 0, 0);
    for (int s = 0; s < 24; s++) begin
      slot(s, nv);
      if (s == 20) chk("seven_before", int'(seq_err), 0);
      if (s == 22) chk("seven_at", int'(seq_err), 1);
    end

    // c1 gating mid-frame: strobes toggle but nothing moves.
    do_reset();
    nv = mk(3, 3, 1, 1, 0, 8'h00, 0, 6, 0, 0, 0, 0);
    for (int s = 0; s < 24; s++) begin
      slot(s, nv);
      if (s == 13) begin
        for (int k = 0; k < 10; k++) begin
          c1 = 1'b0;
          fsm_sel0 = k[0];
          fsm_dac_load = 1'b1;
          fsm_dac_out_sel = k[1];
          ch_acc = 9'($urandom);
          @(posedge MCLK); #1;
          chk("gate_slot_l", int'($signed(dac_slot_l)), 3);
          chk("gate_slot_valid", int'(dac_slot_valid), 1);
          chk("gate_mix_valid", int'(mix_valid), 0);
          chk("gate_seq_err", int'(seq_err), 0);
        end
      end
    end
    slot(0, nv);
    chk_frame("gate_resume", 1'b1, 18, 18, 1'b0);
    // mix_valid must drop on the next MCLK even with c1 low.
    c1 = 1'b0;
    @(posedge MCLK); #1;
    chk("pulse_c1_low", int'(mix_valid), 0);
    chk("pulse_c1_low_mix", int'($signed(mix_l)), 18);

    // Reset at slot 10: outputs clear, the next frame is never reported.
    for (int s = 1; s < 10; s++) slot(s, nv);
    fsm_dac_load = 1'b1;
    fsm_dac_out_sel = 1'b1;
    c1 = 1'b1;
    do_reset();
    chk_frame("midreset", 1'b0, 0, 0, 1'b0);
    chk("midreset_slot_valid", int'(dac_slot_valid), 0);
    nv = mk(2, 2, 1, 1, 0, 8'h00, 0, 6, 0, 0, 0, 0);
    for (int s = 0; s < 24; s++) begin
      slot(s, nv);
      if (s == 0) chk_frame("post_reset_first", 1'b0, 0, 0, 1'b0);
    end
    for (int s = 0; s < 24; s++) begin
      slot(s, nv);
      if (s == 0) chk_frame("post_reset_second", 1'b1, 12, 12, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
